softmax_row_norm: RTL and testbench

Sequential normalisation front-end for the attention softmax. It accepts one row of ROW_LEN non-negative exponent values in Q2.13 and buffers them while accumulating their sum. It then drives each (element, row-sum) pair into the combinational `div_fast` divider and streams the registered quotients out as the normalised row. The block sits between the exponent stage and the attention-weight consumer.

---
 rtl/softmax_row_norm.sv | 115 +++++++++++
 tb/tb_softmax_row_norm.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/softmax_row_norm.sv
// softmax_row_norm: buffers one row of Q2.13 exponents, sums them, then streams element/sum quotients from an external divider
// Optional macro SOFTMAX_NORM_DIV_REG_EN registers the divider operands (two-stage pipeline, two-edge first-output latency)
module softmax_row_norm #(
  parameter int D_W     = 16,
  parameter int ROW_LEN = 16
) (
  input  logic           I_CLK,
  input  logic           I_RST_N,
  input  logic           I_VALID,
  output logic           O_READY,
  input  logic [D_W-1:0] I_DATA,
  output logic [D_W-1:0] O_DIVIDEND,
  output logic [D_W-1:0] O_DIVISOR,
  input  logic [D_W-1:0] I_QUOTIENT,
  output logic           O_VALID,
  input  logic           I_READY,
  output logic [D_W-1:0] O_DATA,
  output logic           O_LAST,
  output logic           O_SAT
);
  localparam int CW = $clog2(ROW_LEN);
  localparam int AW = D_W - 1 + CW;
  localparam logic [D_W-1:0] MAXP = {1'b0, {(D_W-1){1'b1}}};
  localparam logic S_LOAD = 1'b0;
  localparam logic S_NORM = 1'b1;
  logic           r_state, w_state_nxt;
  logic [D_W-1:0] r_buf [ROW_LEN];
  logic [CW-1:0]  r_cnt;
  logic [CW:0]    r_idx;
  logic [AW-1:0]  r_acc, w_acc_nxt;
  logic [D_W-1:0] w_elem, w_div;
  logic           w_accept, w_row_done, w_out_done, w_drv, w_cap, w_issue, w_last_cap;
  assign w_elem     = I_DATA[D_W-1] ? '0 : I_DATA;
  assign w_acc_nxt  = r_acc + AW'(w_elem);
  assign w_div      = (r_acc > AW'(MAXP)) ? MAXP : r_acc[D_W-1:0];
  assign w_accept   = (r_state == S_LOAD) & I_VALID;
  assign w_row_done = w_accept & (r_cnt == CW'(ROW_LEN - 1));
  assign w_out_done = O_VALID & I_READY & O_LAST;
  assign w_drv      = (r_state == S_NORM) & !r_idx[CW];
`ifdef SOFTMAX_NORM_DIV_REG_EN
  logic           r_opv, r_op_last;
  logic [D_W-1:0] r_dvd, r_dvs;
  assign w_cap      = r_opv & (!O_VALID | I_READY);
  assign w_issue    = w_drv & (!r_opv | w_cap);
  assign w_last_cap = r_op_last;
  // Operand stage: launches the next element and drains empty once the row has been issued
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_opv     <= 1'b0;
      r_op_last <= 1'b0;
    end else if (w_issue) begin
      r_dvd     <= r_buf[r_idx[CW-1:0]];
      r_dvs     <= w_div;
      r_opv     <= 1'b1;
      r_op_last <= r_idx[CW-1:0] == CW'(ROW_LEN - 1);
    end else if (w_cap) begin
      r_dvd <= '0;
      r_dvs <= '0;
      r_opv <= 1'b0;
    end
`else
  assign w_cap      = w_drv & (!O_VALID | I_READY);
  assign w_issue    = w_cap;
  assign w_last_cap = r_idx[CW-1:0] == CW'(ROW_LEN - 1);
`endif
  // State register
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) r_state <= S_LOAD;
    else          r_state <= w_state_nxt;
  // Next state: load a full row, then stay in normalise until the last beat is taken
  always_comb
    w_state_nxt = (r_state == S_LOAD) ? (w_row_done ? S_NORM : S_LOAD) : (w_out_done ? S_LOAD : S_NORM);
  // Handshake flag and divider operand drive
  always_comb begin
    O_READY = r_state == S_LOAD;
`ifdef SOFTMAX_NORM_DIV_REG_EN
    O_DIVIDEND = r_dvd;
    O_DIVISOR  = r_dvs;
`else
    O_DIVIDEND = w_drv ? r_buf[r_idx[CW-1:0]] : '0;
    O_DIVISOR  = w_drv ? w_div : '0;
`endif
  end
  // Row buffer holds clamped elements; contents after reset are irrelevant
  always_ff @(posedge I_CLK)
    if (w_accept) r_buf[r_cnt] <= w_elem;
  // Accumulation, issue index, saturation flag and the output register
  always_ff @(posedge I_CLK or negedge I_RST_N)
    if (!I_RST_N) begin
      r_cnt   <= '0;
      r_acc   <= '0;
      r_idx   <= '0;
      O_SAT   <= 1'b0;
      O_VALID <= 1'b0;
      O_DATA  <= '0;
      O_LAST  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
        r_acc <= w_acc_nxt;
      end
      if (w_out_done) r_acc <= '0;
      if (w_row_done) O_SAT <= w_acc_nxt > AW'(MAXP);
      else if (w_accept && r_cnt == '0) O_SAT <= 1'b0;
      if (w_out_done) r_idx <= '0;
      else if (w_issue) r_idx <= r_idx + 1'b1;
      if (w_cap) begin
        O_DATA  <= (O_DIVISOR == '0) ? '0 : I_QUOTIENT;
        O_VALID <= 1'b1;
        O_LAST  <= w_last_cap;
      end else if (I_READY) O_VALID <= 1'b0;
    end
endmodule

// File: tb/tb_softmax_row_norm.sv
// tb_softmax_row_norm: directed and random rows against an arithmetic softmax-normalisation model
module tb_softmax_row_norm;
  localparam int RL = 4;
`ifdef SOFTMAX_NORM_DIV_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 0, rst_n = 0, i_valid = 0, i_ready = 1;
  logic [15:0] i_data = 0, o_dvd, o_dvs, i_quo, o_data;
  logic        o_ready, o_valid, o_last, o_sat;
  logic [31:0] num;
  int          errors = 0, checks = 0;
  logic [15:0] row [RL];
  logic [15:0] exp_q [RL];
  logic        exp_sat = 0, prev_sat = 0;

  always #5 clk = ~clk;

  assign num   = {16'd0, o_dvd} << 13;
  assign i_quo = (o_dvs == 16'd0) ? 16'd0 : 16'(num / {16'd0, o_dvs});

  softmax_row_norm #(.D_W(16), .ROW_LEN(RL)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VALID(i_valid), .O_READY(o_ready), .I_DATA(i_data),
    .O_DIVIDEND(o_dvd), .O_DIVISOR(o_dvs), .I_QUOTIENT(i_quo), .O_VALID(o_valid),
    .I_READY(i_ready), .O_DATA(o_data), .O_LAST(o_last), .O_SAT(o_sat));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_row(input logic [15:0] a, b, c, d);
    int sum, dv;
    row[0] = a; row[1] = b; row[2] = c; row[3] = d;
    sum = 0;
    for (int i = 0; i < RL; i++) sum += row[i][15] ? 0 : int'(row[i]);
    dv = (sum > 32767) ? 32767 : sum;
    exp_sat = sum > 32767;
    for (int i = 0; i < RL; i++)
      exp_q[i] = (dv == 0 || row[i][15]) ? 16'd0 : 16'((int'(row[i]) * 8192) / dv);
  endtask

  task automatic send_row(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("ready_load", o_ready, 1);
      chk("dvd_idle", o_dvd, 0);
      chk("dvs_idle", o_dvs, 0);
      chk("sat_hold", o_sat, (i == 0) ? prev_sat : 1'b0);
      i_valid = 1;
      i_data  = row[i];
      @(posedge clk);
    end
  endtask

  task automatic collect(input int mode);
    int beats, n;
    bit started;
    beats = 0; n = 0; started = 0;
    while (beats < RL && n < 60) begin
      @(negedge clk);
      n++;
      i_valid = 1'($urandom);
      i_data  = 16'($urandom);
      i_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((n - 1) % 4 == 0 || (n - 1) % 4 == 3) : 1'($urandom);
      chk("ready_norm", o_ready, 0);
      if (!started && o_valid) begin
        started = 1;
        chk("latency", n - 1, LAT);
      end
      if (started && mode == 0) chk("stream", o_valid, 1);
      if (o_valid) begin
        chk("data", o_data, exp_q[beats]);
        chk("last", o_last, beats == RL - 1);
        chk("sat", o_sat, exp_sat);
        if (i_ready) beats++;
      end
    end
    chk("beats", beats, RL);
    @(negedge clk);
    i_valid = 0;
    i_ready = 1;
    chk("ready_after", o_ready, 1);
    chk("valid_after", o_valid, 0);
    prev_sat = exp_sat;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_sat", o_sat, 0);
    chk("rst_dvd", o_dvd, 0);
    chk("rst_dvs", o_dvs, 0);
    rst_n = 1;
    set_row(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    chk("model_uniform", exp_q[0], 16'h0800);
    send_row(RL); collect(0);
    set_row(16'h2000, 16'h0000, 16'h0000, 16'h0000);
    send_row(RL); collect(0);
    set_row(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    send_row(RL); collect(0);
    set_row(16'hF000, 16'hF000, 16'hF000, 16'hF000);
    send_row(RL); collect(0);
    set_row(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    send_row(RL); collect(1);
    set_row(16'h2000, 16'h2000, 16'h2000, 16'h2000);
    send_row(2);
    @(negedge clk);
    i_valid = 0;
    rst_n = 0;
    #1;
    chk("midrow_valid", o_valid, 0);
    chk("midrow_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1;
    prev_sat = 0;
    set_row(16'h1000, 16'h1000, 16'h1000, 16'h1000);
    send_row(RL); collect(0);
    send_row(RL);
    @(negedge clk);
    i_valid = 0;
    i_ready = 0;
    repeat (3) @(negedge clk);
    chk("stall_valid", o_valid, 1);
    rst_n = 0;
    #1;
    chk("midout_valid", o_valid, 0);
    chk("midout_data", o_data, 0);
    chk("midout_ready", o_ready, 1);
    @(negedge clk);
    rst_n = 1;
    i_ready = 1;
    prev_sat = 0;
    for (int r = 0; r < 8; r++) begin
      logic [15:0] v [RL];
      for (int i = 0; i < RL; i++)
        v[i] = ($urandom % 8 == 0) ? (16'($urandom) | 16'h8000) : 16'($urandom_range(0, 16'h3FFF));
      set_row(v[0], v[1], v[2], v[3]);
      send_row(RL);
      collect(2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
